// File: rtl/axi2per_pkg.sv
// Shared definitions for the AXI-to-peripheral bridge: AXI response codes,
// the transaction-type encoding used between request and response channels,
// and the response-channel state enum.
package axi2per_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // The bridge encodes a read as 1 on the transaction-type line
    localparam logic TRANS_READ  = 1'b1;
    localparam logic TRANS_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PER,
        RESP
    } rsp_state_e;

endpackage

// File: rtl/axi2per_rsp_channel.sv
// Response stage of the AXI-to-peripheral bridge. Latches the descriptor of
// the granted transaction, waits for the peripheral response, then presents
// it on AXI R (reads) or B (writes) until accepted. The acceptance cycle is
// signalled back to the request channel through trans_r_valid_o.
module axi2per_rsp_channel
    import axi2per_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      per_slave_r_valid_i,
    input  logic                      per_slave_r_opc_i,
    input  logic [31:0]               per_slave_r_rdata_i,

    input  logic                      trans_req_i,
    input  logic                      trans_we_i,
    input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
    output logic                      trans_r_valid_o,

    output logic                      axi_slave_r_valid_o,
    output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
    output logic [1:0]                axi_slave_r_resp_o,
    output logic                      axi_slave_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
    input  logic                      axi_slave_r_ready_i,

    output logic                      axi_slave_b_valid_o,
    output logic [1:0]                axi_slave_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
    input  logic                      axi_slave_b_ready_i
);

    // The lane placement below assumes a 64-bit R channel built from two
    // 32-bit peripheral words; any other width is rejected at elaboration.
    generate
        if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
            $error("axi2per_rsp_channel supports only AXI_DATA_WIDTH = 64");
        end
    endgenerate

    rsp_state_e                state_q, state_d;
    logic                      we_q;
    logic                      lane_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_DATA_WIDTH-1:0] data_q;
    logic [1:0]                resp_q;

    logic                      r_valid;
    logic                      b_valid;
    logic                      handshake;

    // Only bit 2 of the address selects the lane; the rest is unused here.
    logic                      unused_addr_bits;
    assign unused_addr_bits = ^{trans_add_i[AXI_ADDR_WIDTH-1:3], trans_add_i[1:0]};

    assign r_valid   = (state_q == RESP) && (we_q == TRANS_READ);
    assign b_valid   = (state_q == RESP) && (we_q == TRANS_WRITE);
    assign handshake = (r_valid && axi_slave_r_ready_i) || (b_valid && axi_slave_b_ready_i);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: grant -> wait for peripheral -> hold until accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (trans_req_i)         state_d = WAIT_PER;
            WAIT_PER: if (per_slave_r_valid_i) state_d = RESP;
            RESP:     if (handshake)           state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Descriptor capture on grant; only accepted while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q   <= TRANS_WRITE;
            lane_q <= 1'b0;
            id_q   <= '0;
        end else if (state_q == IDLE && trans_req_i) begin
            we_q   <= trans_we_i;
            lane_q <= trans_add_i[2];
            id_q   <= trans_id_i;
        end
    end

    // Response capture; read data is steered into the addressed 32-bit lane.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_q <= RESP_OKAY;
            data_q <= '0;
        end else if (state_q == WAIT_PER && per_slave_r_valid_i) begin
            resp_q <= per_slave_r_opc_i ? RESP_SLVERR : RESP_OKAY;
            if (we_q == TRANS_READ) begin
                data_q <= lane_q ? {per_slave_r_rdata_i, 32'h0} : {32'h0, per_slave_r_rdata_i};
            end
        end
    end

    assign trans_r_valid_o     = handshake;

    assign axi_slave_r_valid_o = r_valid;
    assign axi_slave_r_last_o  = r_valid;
    assign axi_slave_r_data_o  = data_q;
    assign axi_slave_r_resp_o  = resp_q;
    assign axi_slave_r_id_o    = id_q;
    assign axi_slave_r_user_o  = '0;

    assign axi_slave_b_valid_o = b_valid;
    assign axi_slave_b_resp_o  = resp_q;
    assign axi_slave_b_id_o    = id_q;
    assign axi_slave_b_user_o  = '0;

endmodule
